// File: rtl/serial2parallel.sv
// Serial-to-parallel converter: shifts in WIDTH-bit words MSB first and emits each completed word with a one-cycle valid pulse.
// Optional frame-sync hunting with sync_sig is enabled by defining S2P_SYNC_EN.
`timescale 1ns/1ps

module serial2parallel #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_sig,
  input  logic             reset_sig,
  input  logic             serial_sig,
`ifdef S2P_SYNC_EN
  input  logic             sync_sig,
`endif
  output logic [WIDTH-1:0] parallel_sig,
  output logic             valid_sig
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned SW = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt, cnt_nxt;
  logic [SW-1:0]    shreg, shreg_nxt;
  logic [WIDTH-1:0] par_nxt;
  logic [WIDTH-1:0] word;
  logic             valid_nxt;
  logic             shift_en;

`ifdef S2P_SYNC_EN
  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t state, state_nxt;
`endif

  // Only the low WIDTH-1 bits are stored; the current serial bit completes the word.
  assign word = {shreg, serial_sig};

  // Next-state, counter and output-register logic.
  always_comb begin
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    par_nxt   = parallel_sig;
    valid_nxt = 1'b0;
`ifdef S2P_SYNC_EN
    state_nxt = state;
    shift_en  = (state == LOCK) && !sync_sig;
`else
    shift_en  = 1'b1;
`endif

    if (shift_en) begin
      shreg_nxt = word[SW-1:0];
      if (cnt == LAST) begin
        par_nxt   = word;
        valid_nxt = 1'b1;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end

`ifdef S2P_SYNC_EN
    // A sync strobe restarts framing: this bit is the MSB and any partial word is dropped.
    if (sync_sig) begin
      state_nxt = LOCK;
      shreg_nxt = SW'(serial_sig);
      cnt_nxt   = CW'(1);
    end
`endif
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_sig) begin
    if (!reset_sig) begin
      cnt          <= '0;
      shreg        <= '0;
      parallel_sig <= '0;
      valid_sig    <= 1'b0;
`ifdef S2P_SYNC_EN
      state        <= HUNT;
`endif
    end else begin
      cnt          <= cnt_nxt;
      shreg        <= shreg_nxt;
      parallel_sig <= par_nxt;
      valid_sig    <= valid_nxt;
`ifdef S2P_SYNC_EN
      state        <= state_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_serial2parallel.sv
// Self-checking bench for serial2parallel: WIDTH=2 and WIDTH=4 instances share stimulus and are
// compared every cycle against a bit-queue reference model plus directed word expectations.
`timescale 1ns/1ps

module tb_serial2parallel;

`ifdef S2P_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  logic       clk_sig = 1'b0;
  logic       reset_sig = 1'b0;
  logic       serial_sig = 1'b0;
  logic       sync_sig = 1'b0;
  logic [1:0] par2;
  logic       val2;
  logic [3:0] par4;
  logic       val4;

  int checks = 0;
  int failures = 0;

  // Reference model state, index 0 -> WIDTH=2 instance, index 1 -> WIDTH=4 instance.
  int         mw[2];
  int         mn[2];
  bit         mbuf[2][4];
  logic [3:0] mpar[2];
  logic       mval[2];
  bit         mlock[2];

  always #5 clk_sig = ~clk_sig;

  serial2parallel #(.WIDTH(2)) dut2 (
    .clk_sig      (clk_sig),
    .reset_sig    (reset_sig),
    .serial_sig   (serial_sig),
`ifdef S2P_SYNC_EN
    .sync_sig     (sync_sig),
`endif
    .parallel_sig (par2),
    .valid_sig    (val2)
  );

  serial2parallel #(.WIDTH(4)) dut4 (
    .clk_sig      (clk_sig),
    .reset_sig    (reset_sig),
    .serial_sig   (serial_sig),
`ifdef S2P_SYNC_EN
    .sync_sig     (sync_sig),
`endif
    .parallel_sig (par4),
    .valid_sig    (val4)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: collect bits of the current frame; a full frame becomes the word.
  task automatic model_update(input int k, input bit rst, input bit ser, input bit syn);
    int unsigned w;
    if (!rst) begin
      mn[k]   = 0;
      mpar[k] = 4'd0;
      mval[k] = 1'b0;
      mlock[k] = !SYNC_EN;
      return;
    end
    mval[k] = 1'b0;
    if (SYNC_EN && syn) begin
      mn[k]    = 0;
      mlock[k] = 1'b1;
    end
    if (!mlock[k]) return;
    mbuf[k][mn[k]] = ser;
    mn[k]++;
    if (mn[k] == mw[k]) begin
      w = 0;
      for (int i = 0; i < mw[k]; i++) w = w * 2 + int'(mbuf[k][i]);
      mpar[k] = 4'(w);
      mval[k] = 1'b1;
      mn[k]   = 0;
    end
  endtask

  // One clock: drive inputs, update the model at the edge, compare both instances just after it.
  task automatic step(input bit rst, input bit ser, input bit syn);
    reset_sig  = rst;
    serial_sig = ser;
    sync_sig   = syn;
    @(posedge clk_sig);
    model_update(0, rst, ser, syn);
    model_update(1, rst, ser, syn);
    #1;
    check("par_w2", {2'b00, par2}, mpar[0]);
    check("val_w2", {3'b000, val2}, {3'b000, mval[0]});
    check("par_w4", par4, mpar[1]);
    check("val_w4", {3'b000, val4}, {3'b000, mval[1]});
  endtask

  task automatic send4(input logic [3:0] bits, input bit first_sync);
    for (int i = 3; i >= 0; i--) step(1'b1, bits[i], (i == 3) && first_sync);
  endtask

  initial begin
    logic [3:0] w4;
    logic [1:0] w2;
    logic [1:0] t2_words[3];
    mw[0] = 2;
    mw[1] = 4;
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0; mpar[k] = 4'd0; mval[k] = 1'b0; mlock[k] = !SYNC_EN;
    end
    #2;

    // T1: reset held with toggling serial data
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i[0], 1'b0);
      check("t1_par", par4, 4'd0);
      check("t1_val", {3'b000, val4}, 4'd0);
    end

    // T3: 1011 then 0110, value held between words
    if (SYNC_EN) step(1'b1, 1'b0, 1'b1);
    w4 = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, w4[i], SYNC_EN && (i == 3));
      if (i != 0) check("t3_nopulse", {3'b000, val4}, 4'd0);
    end
    check("t3_word1", par4, 4'b1011);
    check("t3_valid1", {3'b000, val4}, 4'd1);
    w4 = 4'b0110;
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, w4[i], 1'b0);
      if (i != 0) check("t3_hold", par4, 4'b1011);
    end
    check("t3_word2", par4, 4'b0110);
    check("t3_valid2", {3'b000, val4}, 4'd1);

    // T4: reset after two bits, then 1100
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t4_rst_clear", par4, 4'd0);
    w4 = 4'b1100;
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, w4[i], SYNC_EN && (i == 3));
      if (i != 0) check("t4_no_stale", {3'b000, val4}, 4'd0);
    end
    check("t4_word", par4, 4'b1100);

    // T2: WIDTH=2 link, transmitter sends 10, 01, 11 MSB first after a shared reset
    t2_words[0] = 2'b10; t2_words[1] = 2'b01; t2_words[2] = 2'b11;
    step(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      w2 = t2_words[n];
      step(1'b1, w2[1], SYNC_EN && (n == 0));
      check("t2_gap", {3'b000, val2}, 4'd0);
      step(1'b1, w2[0], 1'b0);
      check("t2_word", {2'b00, par2}, {2'b00, w2});
      check("t2_pulse", {3'b000, val2}, 4'd1);
    end

`ifdef S2P_SYNC_EN
    // T5: no lock without sync, then sync with MSB=1 followed by 0,0,1
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'($urandom_range(1)), 1'b0);
      check("t5_hunt_nopulse", {3'b000, val4}, 4'd0);
    end
    send4(4'b1001, 1'b1);
    check("t5_word", par4, 4'b1001);
    check("t5_valid", {3'b000, val4}, 4'd1);

    // T6: three bits, sync on the fourth-bit slot, then 0111 with the sync bit as MSB
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("t6_abort_nopulse", {3'b000, val4}, 4'd0);
    check("t6_abort_hold", par4, 4'b1001);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("t6_word", par4, 4'b0111);
    check("t6_valid", {3'b000, val4}, 4'd1);
`endif

    // Random traffic with occasional resets and sync strobes
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(40) != 0), 1'($urandom_range(1)), ($urandom_range(12) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
